axil_stream_tx_bridge: RTL and testbench
========================================

// Module: axil_stream_tx_bridge
// PURPOSE
//  AXI4-Lite slave that turns CPU register writes into an AXI4-Stream word flow.
//  Writes to the DATA register are buffered in a synchronous FIFO. The FIFO drains
//  through an AXI4_STREAM_BASIC.MASTER port to the downstream stream consumer.
//  STATUS and CTRL registers give software flow control (level, full, empty, flush).
// PARAMETERS
//  ADDR_WIDTH  4   AXI4-Lite address width; must be >= 4
//  DATA_WIDTH  32  AXI4-Lite and stream data width; 32 or 64
//  FIFO_DEPTH  8   stream FIFO entries; power of two, 2..128
// PORTS
//  aclk     input   1          single clock for all logic
//  aresetn  input   1          asynchronous active-low reset
//  s_axil   AXI4_LITE.SLAVE    iface  ADDR_WIDTH/DATA_WIDTH  register access port
//  m_axis   AXI4_STREAM_BASIC.MASTER  iface  DATA_WIDTH      outgoing word stream
// BEHAVIOUR
//  Reset: asynchronous on aresetn low.
//   - bvalid=0, rvalid=0, bresp=0, rresp=0, rdata=0.
//   - FIFO empty: tValid=0, tData=0. Write and read FSMs go to IDLE.
//   - awready, wready and arready are held 0 while aresetn is low.
//   - Reset mid-transaction aborts that transaction; no response is issued.
//  Register decode uses addr[3:2]. Any nonzero addr bit above bit 3 -> DECERR (2'b11).
//   - 0x0 DATA    WO: write pushes wdata; read returns 0 with OKAY.
//   - 0x4 STATUS  RO: [0]=full, [1]=empty, [15:8]=level (0..FIFO_DEPTH); write -> SLVERR.
//   - 0x8 CTRL    W:  bit0=1 flushes the FIFO (self-clearing); read returns 0.
//   - 0xC reserved -> DECERR (see CONFIGURATION).
//  Response codes: OKAY=2'b00, SLVERR=2'b10, DECERR=2'b11.
//  Write FSM states W_IDLE and W_RESP.
//   - W_IDLE: awready=wready=1 only when awvalid && wvalid (AW and W are accepted jointly).
//   - On the handshake -> W_RESP. bvalid rises next cycle.
//   - W_RESP: hold bvalid and bresp until bready, then -> W_IDLE. No new AW/W is accepted in W_RESP.
//  DATA write:
//   - wstrb must be all ones, else SLVERR and no push.
//   - FIFO full at the handshake cycle -> SLVERR and the word is dropped.
//   - Otherwise OKAY and push. The word is visible on tValid/tData on cycle T+1.
//  Read FSM states R_IDLE and R_DATA.
//   - R_IDLE: arready=1. On the handshake -> R_DATA and register rdata/rresp.
//   - R_DATA: rvalid=1 and rdata held until rready, then -> R_IDLE.
//   - STATUS is sampled in the AR handshake cycle.
//  Read and write FSMs are independent; both may complete in the same cycle.
//  Stream side:
//   - tValid = !empty; tData = FIFO head, held stable while tValid && !tReady.
//   - Pop on tValid && tReady.
//   - Push and pop in the same cycle: both occur and level is unchanged. A push while full
//     is rejected even if a pop happens that cycle.
//  Flush: level goes to 0 the cycle after the CTRL write handshake; tValid drops that cycle.
//   Flush overrides a simultaneous pop.
//  Pointers are log2(FIFO_DEPTH) bits and wrap modulo depth. level counter is log2(FIFO_DEPTH)+1 bits.
// CONFIGURATION
//  AXIL_STREAM_OVF_CNT_EN defined:
//   - 0xC becomes OVF_COUNT, RO: [15:0] counts DATA writes rejected as full.
//   - Saturates at 16'hFFFF, cleared by flush and reset. Writes to it -> SLVERR.
//  AXIL_STREAM_OVF_CNT_EN undefined: no counter logic; 0xC read/write -> DECERR, rdata=0.
// TESTING
//  - Reset: hold aresetn=0 for 3 cycles with awvalid/arvalid=1 -> all readies 0, bvalid=rvalid=tValid=0.
//  - Write 0xA5A5_0001 to 0x0, tReady=1 -> bresp=OKAY at T+1; tData=0xA5A5_0001 with tValid at T+1.
//  - tReady=0, write DATA_DEPTH+1 words -> first 8 OKAY, 9th SLVERR.
//    STATUS read = 0x0000_0801; then drain 8 words in order with no 9th.
//  - Simultaneous pop and push at level 3 -> level stays 3; word order preserved.
//  - Flush: 5 words queued, write 0x1 to 0x8 -> next cycle tValid=0, STATUS=0x0000_0002.
//  - Errors: write 0x4 -> SLVERR; read 0xC (macro off) -> DECERR, rdata=0.
//    Write DATA with wstrb=4'b0111 -> SLVERR, level unchanged.
//  - Macro on: 3 full rejections -> OVF_COUNT=3; after flush, OVF_COUNT=0.

Source files
------------

// File: rtl/axil_stream_tx_bridge.sv
// AXI4-Lite register front end feeding a FIFO that drains as an AXI4-Stream word flow.
// Optional overflow counter at 0xC is enabled by defining AXIL_STREAM_OVF_CNT_EN.
module axil_stream_tx_bridge #(
  parameter int unsigned ADDR_WIDTH = 4,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned FIFO_DEPTH = 8
) (
  input  logic                      aclk,
  input  logic                      aresetn,
  input  logic [ADDR_WIDTH-1:0]     s_axil_awaddr,
  input  logic                      s_axil_awvalid,
  output logic                      s_axil_awready,
  input  logic [DATA_WIDTH-1:0]     s_axil_wdata,
  input  logic [DATA_WIDTH/8-1:0]   s_axil_wstrb,
  input  logic                      s_axil_wvalid,
  output logic                      s_axil_wready,
  output logic [1:0]                s_axil_bresp,
  output logic                      s_axil_bvalid,
  input  logic                      s_axil_bready,
  input  logic [ADDR_WIDTH-1:0]     s_axil_araddr,
  input  logic                      s_axil_arvalid,
  output logic                      s_axil_arready,
  output logic [DATA_WIDTH-1:0]     s_axil_rdata,
  output logic [1:0]                s_axil_rresp,
  output logic                      s_axil_rvalid,
  input  logic                      s_axil_rready,
  output logic                      m_axis_tvalid,
  output logic [DATA_WIDTH-1:0]     m_axis_tdata,
  input  logic                      m_axis_tready
);

  localparam int unsigned PTR_W  = $clog2(FIFO_DEPTH);
  localparam int unsigned LVL_W  = PTR_W + 1;
  localparam int unsigned STRB_W = DATA_WIDTH / 8;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;
  localparam logic [ADDR_WIDTH-1:0] LOW_MASK = ADDR_WIDTH'(4'hF);

  typedef enum logic {W_IDLE, W_RESP} w_state_e;
  typedef enum logic {R_IDLE, R_DATA} r_state_e;

  w_state_e w_state_q, w_state_d;
  r_state_e r_state_q, r_state_d;
  logic [1:0]            bresp_q, bresp_d;
  logic [1:0]            rresp_q, rresp_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0]      level_q, level_d;
  logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];

  logic aw_hs, ar_hs, aw_hi_bad, ar_hi_bad;
  logic fifo_full, fifo_empty, push, pop, flush;
  logic [DATA_WIDTH-1:0] status;
`ifdef AXIL_STREAM_OVF_CNT_EN
  logic        ovf_hit;
  logic [15:0] ovf_cnt_q, ovf_cnt_d;
`endif

  assign fifo_full  = (level_q == LVL_W'(FIFO_DEPTH));
  assign fifo_empty = (level_q == '0);
  assign aw_hi_bad  = |(s_axil_awaddr & ~LOW_MASK);
  assign ar_hi_bad  = |(s_axil_araddr & ~LOW_MASK);
  // Readies stay low throughout reset, so handshakes are gated by aresetn.
  assign aw_hs  = aresetn && (w_state_q == W_IDLE) && s_axil_awvalid && s_axil_wvalid;
  assign ar_hs  = aresetn && (r_state_q == R_IDLE) && s_axil_arvalid;
  assign pop    = !fifo_empty && m_axis_tready;
  assign status = DATA_WIDTH'({8'(level_q), 6'd0, fifo_empty, fifo_full});

  // State registers
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      w_state_q <= W_IDLE;
      r_state_q <= R_IDLE;
    end else begin
      w_state_q <= w_state_d;
      r_state_q <= r_state_d;
    end
  end

  // Next-state logic for both independent channels
  always_comb begin
    w_state_d = w_state_q;
    r_state_d = r_state_q;
    case (w_state_q)
      W_IDLE:  if (aw_hs) w_state_d = W_RESP;
      W_RESP:  if (s_axil_bready) w_state_d = W_IDLE;
      default: w_state_d = W_IDLE;
    endcase
    case (r_state_q)
      R_IDLE:  if (ar_hs) r_state_d = R_DATA;
      R_DATA:  if (s_axil_rready) r_state_d = R_IDLE;
      default: r_state_d = R_IDLE;
    endcase
  end

  // Handshake and stream outputs
  always_comb begin
    s_axil_awready = aw_hs;
    s_axil_wready  = aw_hs;
    s_axil_bvalid  = (w_state_q == W_RESP);
    s_axil_bresp   = bresp_q;
    s_axil_arready = aresetn && (r_state_q == R_IDLE);
    s_axil_rvalid  = (r_state_q == R_DATA);
    s_axil_rdata   = rdata_q;
    s_axil_rresp   = rresp_q;
    m_axis_tvalid  = !fifo_empty;
    m_axis_tdata   = fifo_empty ? '0 : mem_q[rd_ptr_q];
  end

  // Write decode: response code plus push/flush strobes
  always_comb begin
    bresp_d = bresp_q;
    push    = 1'b0;
    flush   = 1'b0;
`ifdef AXIL_STREAM_OVF_CNT_EN
    ovf_hit = 1'b0;
`endif
    if (aw_hs) begin
      if (aw_hi_bad) begin
        bresp_d = RESP_DECERR;
      end else begin
        case (s_axil_awaddr[3:2])
          2'd0: begin
            if (s_axil_wstrb != {STRB_W{1'b1}}) begin
              bresp_d = RESP_SLVERR;
            end else if (fifo_full) begin
              bresp_d = RESP_SLVERR;
`ifdef AXIL_STREAM_OVF_CNT_EN
              ovf_hit = 1'b1;
`endif
            end else begin
              bresp_d = RESP_OKAY;
              push    = 1'b1;
            end
          end
          2'd1: bresp_d = RESP_SLVERR;
          2'd2: begin
            bresp_d = RESP_OKAY;
            flush   = s_axil_wdata[0];
          end
          default: begin
`ifdef AXIL_STREAM_OVF_CNT_EN
            bresp_d = RESP_SLVERR;
`else
            bresp_d = RESP_DECERR;
`endif
          end
        endcase
      end
    end
  end

  // Read decode, sampled on the AR handshake
  always_comb begin
    rdata_d = rdata_q;
    rresp_d = rresp_q;
    if (ar_hs) begin
      rdata_d = '0;
      rresp_d = RESP_OKAY;
      if (ar_hi_bad) begin
        rresp_d = RESP_DECERR;
      end else begin
        case (s_axil_araddr[3:2])
          2'd1: rdata_d = status;
          2'd3: begin
`ifdef AXIL_STREAM_OVF_CNT_EN
            rdata_d = DATA_WIDTH'(ovf_cnt_q);
`else
            rresp_d = RESP_DECERR;
`endif
          end
          default: rdata_d = '0;
        endcase
      end
    end
  end

  // FIFO bookkeeping; flush wins over any concurrent pop
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      case ({push, pop})
        2'b10:   level_d = level_q + LVL_W'(1);
        2'b01:   level_d = level_q - LVL_W'(1);
        default: level_d = level_q;
      endcase
    end
  end

`ifdef AXIL_STREAM_OVF_CNT_EN
  always_comb begin
    ovf_cnt_d = ovf_cnt_q;
    if (flush) ovf_cnt_d = '0;
    else if (ovf_hit && (ovf_cnt_q != 16'hFFFF)) ovf_cnt_d = ovf_cnt_q + 16'd1;
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) ovf_cnt_q <= '0;
    else          ovf_cnt_q <= ovf_cnt_d;
  end
`endif

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      bresp_q  <= RESP_OKAY;
      rresp_q  <= RESP_OKAY;
      rdata_q  <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      bresp_q  <= bresp_d;
      rresp_q  <= rresp_d;
      rdata_q  <= rdata_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  // Storage array; entries are only observed once written
  always_ff @(posedge aclk) begin
    if (push) mem_q[wr_ptr_q] <= s_axil_wdata;
  end

endmodule

// File: tb/tb_axil_stream_tx_bridge.sv
// Directed self-checking bench for axil_stream_tx_bridge (default parameters).
module tb_axil_stream_tx_bridge;

  localparam logic [1:0] OKAY   = 2'b00;
  localparam logic [1:0] SLVERR = 2'b10;
  localparam logic [1:0] DECERR = 2'b11;

  logic        aclk = 1'b0;
  logic        aresetn;
  logic [3:0]  awaddr, araddr;
  logic        awvalid, wvalid, bready, arvalid, rready, tready;
  logic        awready, wready, bvalid, arready, rvalid, tvalid;
  logic [31:0] wdata, rdata, tdata;
  logic [3:0]  wstrb;
  logic [1:0]  bresp, rresp;

  int checks = 0;
  int errors = 0;

  always #5 aclk = ~aclk;

  axil_stream_tx_bridge dut (
    .aclk(aclk), .aresetn(aresetn),
    .s_axil_awaddr(awaddr), .s_axil_awvalid(awvalid), .s_axil_awready(awready),
    .s_axil_wdata(wdata), .s_axil_wstrb(wstrb), .s_axil_wvalid(wvalid), .s_axil_wready(wready),
    .s_axil_bresp(bresp), .s_axil_bvalid(bvalid), .s_axil_bready(bready),
    .s_axil_araddr(araddr), .s_axil_arvalid(arvalid), .s_axil_arready(arready),
    .s_axil_rdata(rdata), .s_axil_rresp(rresp), .s_axil_rvalid(rvalid), .s_axil_rready(rready),
    .m_axis_tvalid(tvalid), .m_axis_tdata(tdata), .m_axis_tready(tready)
  );

  // Starts and ends just after a rising edge; samples bresp and the stream one half-cycle after the handshake.
  task automatic axil_write(input logic [3:0] addr, input logic [31:0] data, input logic [3:0] strb,
                            output logic [1:0] resp, output int lat, output logic tv, output logic [31:0] td);
    int n = 0;
    awaddr = addr; wdata = data; wstrb = strb; awvalid = 1'b1; wvalid = 1'b1;
    @(negedge aclk);
    while (!awready && n < 20) begin @(negedge aclk); n++; end
    if (!awready) begin checks++; errors++; $display("FAIL aw_timeout addr=%h", addr); end
    @(posedge aclk); #1;
    awvalid = 1'b0; wvalid = 1'b0;
    lat = 0;
    @(negedge aclk);
    while (!bvalid && lat < 20) begin @(negedge aclk); lat++; end
    if (!bvalid) begin checks++; errors++; $display("FAIL b_timeout addr=%h", addr); end
    resp = bresp; tv = tvalid; td = tdata;
    @(posedge aclk); #1;
  endtask

  task automatic axil_read(input logic [3:0] addr, output logic [31:0] data, output logic [1:0] resp);
    int n = 0;
    araddr = addr; arvalid = 1'b1;
    @(negedge aclk);
    while (!arready && n < 20) begin @(negedge aclk); n++; end
    if (!arready) begin checks++; errors++; $display("FAIL ar_timeout addr=%h", addr); end
    @(posedge aclk); #1;
    arvalid = 1'b0;
    n = 0;
    @(negedge aclk);
    while (!rvalid && n < 20) begin @(negedge aclk); n++; end
    if (!rvalid) begin checks++; errors++; $display("FAIL r_timeout addr=%h", addr); end
    data = rdata; resp = rresp;
    @(posedge aclk); #1;
  endtask

  task automatic test_reset();
    aresetn = 1'b0; awvalid = 1'b1; wvalid = 1'b1; arvalid = 1'b1;
    awaddr = 4'h0; araddr = 4'h4; wdata = 32'h1; wstrb = 4'hF;
    repeat (3) begin
      @(negedge aclk);
      checks++;
      if ({awready, wready, arready, bvalid, rvalid, tvalid} !== 6'b0) begin
        errors++; $display("FAIL reset_ctl got=%b exp=000000", {awready, wready, arready, bvalid, rvalid, tvalid});
      end
    end
    checks++;
    if (tdata !== 32'h0 || rdata !== 32'h0 || bresp !== OKAY || rresp !== OKAY) begin
      errors++; $display("FAIL reset_data tdata=%h rdata=%h bresp=%b rresp=%b exp zeros", tdata, rdata, bresp, rresp);
    end
    awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
    @(posedge aclk); #1;
    aresetn = 1'b1;
    @(posedge aclk); #1;
  endtask

  task automatic test_single_write();
    logic [1:0] r; int lat; logic tv; logic [31:0] td;
    tready = 1'b1;
    axil_write(4'h0, 32'hA5A5_0001, 4'hF, r, lat, tv, td);
    checks++;
    if (r !== OKAY || lat !== 0) begin errors++; $display("FAIL single_bresp got=%b lat=%0d exp=00 lat=0", r, lat); end
    checks++;
    if (tv !== 1'b1 || td !== 32'hA5A5_0001) begin
      errors++; $display("FAIL single_stream tv=%b td=%h exp tv=1 td=a5a50001", tv, td);
    end
    @(negedge aclk);
    checks++;
    if (tvalid !== 1'b0) begin errors++; $display("FAIL single_popped tvalid=%b exp=0", tvalid); end
    tready = 1'b0;
    @(posedge aclk); #1;
  endtask

  task automatic test_overflow();
    logic [1:0] r, exp_r; int lat; logic tv; logic [31:0] td, rd;
    tready = 1'b0;
    for (int i = 0; i < 9; i++) begin
      exp_r = (i < 8) ? OKAY : SLVERR;
      axil_write(4'h0, 32'h100 + 32'(i), 4'hF, r, lat, tv, td);
      checks++;
      if (r !== exp_r) begin errors++; $display("FAIL ovf_bresp[%0d] got=%b exp=%b", i, r, exp_r); end
    end
    axil_read(4'h4, rd, r);
    checks++;
    if (rd !== 32'h0000_0801 || r !== OKAY) begin errors++; $display("FAIL ovf_status got=%h/%b exp=00000801/00", rd, r); end
    tready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge aclk);
      checks++;
      if (tvalid !== 1'b1 || tdata !== 32'h100 + 32'(i)) begin
        errors++; $display("FAIL ovf_drain[%0d] tv=%b td=%h exp=%h", i, tvalid, tdata, 32'h100 + 32'(i));
      end
    end
    @(negedge aclk);
    checks++;
    if (tvalid !== 1'b0) begin errors++; $display("FAIL ovf_no_ninth tvalid=%b exp=0", tvalid); end
    tready = 1'b0;
    @(posedge aclk); #1;
    axil_read(4'h4, rd, r);
    checks++;
    if (rd !== 32'h0000_0002) begin errors++; $display("FAIL ovf_status_empty got=%h exp=00000002", rd); end
  endtask

  task automatic test_push_pop();
    logic [1:0] r; int lat; logic tv; logic [31:0] td, rd;
    tready = 1'b0;
    for (int i = 0; i < 3; i++) axil_write(4'h0, 32'h200 + 32'(i), 4'hF, r, lat, tv, td);
    awaddr = 4'h0; wdata = 32'h203; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1; tready = 1'b1;
    @(negedge aclk);
    checks++;
    if (awready !== 1'b1 || tvalid !== 1'b1 || tdata !== 32'h200) begin
      errors++; $display("FAIL pp_same_cycle awready=%b tv=%b td=%h exp 1/1/200", awready, tvalid, tdata);
    end
    @(posedge aclk); #1;
    awvalid = 1'b0; wvalid = 1'b0; tready = 1'b0;
    @(negedge aclk);
    checks++;
    if (bvalid !== 1'b1 || bresp !== OKAY) begin errors++; $display("FAIL pp_bresp bvalid=%b bresp=%b exp 1/00", bvalid, bresp); end
    @(posedge aclk); #1;
    axil_read(4'h4, rd, r);
    checks++;
    if (rd !== 32'h0000_0300) begin errors++; $display("FAIL pp_level got=%h exp=00000300", rd); end
    tready = 1'b1;
    for (int i = 1; i < 4; i++) begin
      @(negedge aclk);
      checks++;
      if (tvalid !== 1'b1 || tdata !== 32'h200 + 32'(i)) begin
        errors++; $display("FAIL pp_order[%0d] tv=%b td=%h exp=%h", i, tvalid, tdata, 32'h200 + 32'(i));
      end
    end
    @(negedge aclk);
    checks++;
    if (tvalid !== 1'b0) begin errors++; $display("FAIL pp_empty tvalid=%b exp=0", tvalid); end
    tready = 1'b0;
    @(posedge aclk); #1;
  endtask

  task automatic test_flush();
    logic [1:0] r; int lat; logic tv; logic [31:0] td, rd;
    tready = 1'b0;
    for (int i = 0; i < 5; i++) axil_write(4'h0, 32'h300 + 32'(i), 4'hF, r, lat, tv, td);
    axil_write(4'h8, 32'h1, 4'hF, r, lat, tv, td);
    checks++;
    if (r !== OKAY || tv !== 1'b0) begin errors++; $display("FAIL flush_ctrl bresp=%b tv=%b exp 00/0", r, tv); end
    axil_read(4'h4, rd, r);
    checks++;
    if (rd !== 32'h0000_0002) begin errors++; $display("FAIL flush_status got=%h exp=00000002", rd); end
    axil_write(4'h0, 32'h3FF, 4'hF, r, lat, tv, td);
    checks++;
    if (r !== OKAY || tv !== 1'b1 || td !== 32'h3FF) begin
      errors++; $display("FAIL flush_after bresp=%b tv=%b td=%h exp 00/1/3ff", r, tv, td);
    end
    axil_write(4'h8, 32'h1, 4'hF, r, lat, tv, td);
  endtask

  task automatic test_errors();
    logic [1:0] r; int lat; logic tv; logic [31:0] td, rd;
    tready = 1'b0;
    axil_write(4'h4, 32'h55, 4'hF, r, lat, tv, td);
    checks++;
    if (r !== SLVERR || tv !== 1'b0) begin errors++; $display("FAIL err_status_wr bresp=%b tv=%b exp 10/0", r, tv); end
    axil_read(4'hC, rd, r);
    checks++;
`ifdef AXIL_STREAM_OVF_CNT_EN
    if (r !== OKAY || rd !== 32'h0) begin errors++; $display("FAIL err_rd_c got=%h/%b exp=00000000/00", rd, r); end
`else
    if (r !== DECERR || rd !== 32'h0) begin errors++; $display("FAIL err_rd_c got=%h/%b exp=00000000/11", rd, r); end
`endif
    axil_write(4'hC, 32'h1, 4'hF, r, lat, tv, td);
    checks++;
`ifdef AXIL_STREAM_OVF_CNT_EN
    if (r !== SLVERR) begin errors++; $display("FAIL err_wr_c got=%b exp=10", r); end
`else
    if (r !== DECERR) begin errors++; $display("FAIL err_wr_c got=%b exp=11", r); end
`endif
    axil_write(4'h0, 32'h400, 4'hF, r, lat, tv, td);
    axil_write(4'h0, 32'h401, 4'b0111, r, lat, tv, td);
    checks++;
    if (r !== SLVERR) begin errors++; $display("FAIL err_wstrb got=%b exp=10", r); end
    axil_read(4'h4, rd, r);
    checks++;
    if (rd !== 32'h0000_0100) begin errors++; $display("FAIL err_wstrb_level got=%h exp=00000100", rd); end
    axil_read(4'h0, rd, r);
    checks++;
    if (rd !== 32'h0 || r !== OKAY) begin errors++; $display("FAIL err_rd_data got=%h/%b exp=00000000/00", rd, r); end
    axil_read(4'h8, rd, r);
    checks++;
    if (rd !== 32'h0 || r !== OKAY) begin errors++; $display("FAIL err_rd_ctrl got=%h/%b exp=00000000/00", rd, r); end
    axil_write(4'h8, 32'h1, 4'hF, r, lat, tv, td);
  endtask

  task automatic test_bresp_hold();
    awaddr = 4'h4; wdata = 32'h0; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1; bready = 1'b0;
    @(negedge aclk);
    @(posedge aclk); #1;
    for (int i = 0; i < 3; i++) begin
      @(negedge aclk);
      checks++;
      if (bvalid !== 1'b1 || bresp !== SLVERR || awready !== 1'b0 || wready !== 1'b0) begin
        errors++; $display("FAIL hold[%0d] bvalid=%b bresp=%b awready=%b wready=%b exp 1/10/0/0", i, bvalid, bresp, awready, wready);
      end
    end
    awvalid = 1'b0; wvalid = 1'b0; bready = 1'b1;
    @(posedge aclk); #1;
    @(negedge aclk);
    checks++;
    if (bvalid !== 1'b0) begin errors++; $display("FAIL hold_release bvalid=%b exp=0", bvalid); end
    @(posedge aclk); #1;
  endtask

`ifdef AXIL_STREAM_OVF_CNT_EN
  task automatic test_ovf_count();
    logic [1:0] r; int lat; logic tv; logic [31:0] td, rd;
    tready = 1'b0;
    for (int i = 0; i < 11; i++) axil_write(4'h0, 32'h500 + 32'(i), 4'hF, r, lat, tv, td);
    axil_read(4'hC, rd, r);
    checks++;
    if (rd !== 32'd3 || r !== OKAY) begin errors++; $display("FAIL ovf_cnt got=%h/%b exp=00000003/00", rd, r); end
    axil_write(4'h8, 32'h1, 4'hF, r, lat, tv, td);
    axil_read(4'hC, rd, r);
    checks++;
    if (rd !== 32'd0) begin errors++; $display("FAIL ovf_cnt_flush got=%h exp=00000000", rd); end
  endtask
`endif

  initial begin
    aresetn = 1'b1; awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
    bready = 1'b1; rready = 1'b1; tready = 1'b0;
    awaddr = '0; araddr = '0; wdata = '0; wstrb = '0;
    #1;
    test_reset();
    test_single_write();
    test_overflow();
    test_push_pop();
    test_flush();
    test_errors();
    test_bresp_hold();
`ifdef AXIL_STREAM_OVF_CNT_EN
    test_ovf_count();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

endmodule
